// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - writeback collector: per-source skid FIFOs, round-robin grant, registered CDB broadcast
module cdb_arbiter #(
  parameter int XLEN       = 32,
  parameter int PREG_W     = 7,
  parameter int ROB_TAG_W  = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 alu_wb_valid_i,
  input  logic                 lsu_wb_valid_i,
  input  logic                 bru_wb_valid_i,
  output logic                 alu_wb_ready_o,
  output logic                 lsu_wb_ready_o,
  output logic                 bru_wb_ready_o,
  input  logic [PREG_W-1:0]    alu_wb_tag_i,
  input  logic [PREG_W-1:0]    lsu_wb_tag_i,
  input  logic [PREG_W-1:0]    bru_wb_tag_i,
  input  logic [XLEN-1:0]      alu_wb_data_i,
  input  logic [XLEN-1:0]      lsu_wb_data_i,
  input  logic [XLEN-1:0]      bru_wb_data_i,
  input  logic [ROB_TAG_W-1:0] alu_wb_rob_tag_i,
  input  logic [ROB_TAG_W-1:0] lsu_wb_rob_tag_i,
  input  logic [ROB_TAG_W-1:0] bru_wb_rob_tag_i,
  input  logic                 alu_wb_rd_used_i,
  input  logic                 lsu_wb_rd_used_i,
  input  logic                 bru_wb_rd_used_i,
  output logic                 cdb_valid_o,
  output logic [PREG_W-1:0]    cdb_tag_o,
  output logic [XLEN-1:0]      cdb_data_o,
  output logic [ROB_TAG_W-1:0] cdb_rob_tag_o,
  output logic                 cdb_rd_used_o,
  output logic [1:0]           cdb_src_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PREG_W + XLEN + ROB_TAG_W + 1;

  typedef logic [EW-1:0] entry_t;

  logic [2:0] in_valid;
  logic [2:0] ready;
  logic [2:0] push;
  logic [2:0] pop;
  logic [2:0] nonempty;
  entry_t     in_entry [3];
  entry_t     head     [3];

  logic       grant_valid;
  logic [1:0] grant_src;
  logic [1:0] cand;
  logic [1:0] rr;

  assign in_valid    = {bru_wb_valid_i, lsu_wb_valid_i, alu_wb_valid_i};
  assign in_entry[0] = {alu_wb_tag_i, alu_wb_data_i, alu_wb_rob_tag_i, alu_wb_rd_used_i};
  assign in_entry[1] = {lsu_wb_tag_i, lsu_wb_data_i, lsu_wb_rob_tag_i, lsu_wb_rd_used_i};
  assign in_entry[2] = {bru_wb_tag_i, bru_wb_data_i, bru_wb_rob_tag_i, bru_wb_rd_used_i};

  assign alu_wb_ready_o = ready[0];
  assign lsu_wb_ready_o = ready[1];
  assign bru_wb_ready_o = ready[2];

  for (genvar g = 0; g < 3; g++) begin : g_src
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    // Ready looks only at the registered count, so a full FIFO stays closed even while popping.
    assign ready[g]    = count < CW'(FIFO_DEPTH);
    assign nonempty[g] = count != '0;
    assign push[g]     = in_valid[g] && ready[g] && !flush_i;
    assign pop[g]      = grant_valid && (grant_src == 2'(g)) && !flush_i;
    assign head[g]     = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else if (flush_i) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push[g]) wptr <= wptr + AW'(1);
        if (pop[g])  rptr <= rptr + AW'(1);
        case ({push[g], pop[g]})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) mem[wptr] <= in_entry[g];
    end
  end

  // Scan ALU->LSU->BRU starting at the round-robin pointer.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = rr;
    cand        = rr;
    for (int k = 0; k < 3; k++) begin
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_src   = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr            <= 2'd0;
      cdb_valid_o   <= 1'b0;
      cdb_tag_o     <= '0;
      cdb_data_o    <= '0;
      cdb_rob_tag_o <= '0;
      cdb_rd_used_o <= 1'b0;
      cdb_src_o     <= 2'd0;
    end else if (flush_i) begin
      cdb_valid_o <= 1'b0;
    end else begin
      cdb_valid_o <= grant_valid;
      if (grant_valid) begin
        rr <= (grant_src == 2'd2) ? 2'd0 : grant_src + 2'd1;
        {cdb_tag_o, cdb_data_o, cdb_rob_tag_o, cdb_rd_used_o} <= head[grant_src];
        cdb_src_o <= grant_src;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized self-checking bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;
  localparam int XLEN = 32, PREG_W = 7, ROB_TAG_W = 5, DEPTH = 2;

  typedef struct packed {
    logic [PREG_W-1:0]    tag;
    logic [XLEN-1:0]      data;
    logic [ROB_TAG_W-1:0] rob;
    logic                 rd;
  } res_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [2:0] v_in = 3'b000;
  res_t r_in [3];
  logic alu_rdy, lsu_rdy, bru_rdy;
  logic cdb_valid_o, cdb_rd_used_o;
  logic [PREG_W-1:0] cdb_tag_o;
  logic [XLEN-1:0] cdb_data_o;
  logic [ROB_TAG_W-1:0] cdb_rob_tag_o;
  logic [1:0] cdb_src_o;
  res_t dut_bus;
  logic [2:0] dut_rdy;
  assign dut_bus = {cdb_tag_o, cdb_data_o, cdb_rob_tag_o, cdb_rd_used_o};
  assign dut_rdy = {bru_rdy, lsu_rdy, alu_rdy};

  always #5 clk = ~clk;

  cdb_arbiter #(.XLEN(XLEN), .PREG_W(PREG_W), .ROB_TAG_W(ROB_TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .alu_wb_valid_i(v_in[0]), .lsu_wb_valid_i(v_in[1]), .bru_wb_valid_i(v_in[2]),
    .alu_wb_ready_o(alu_rdy), .lsu_wb_ready_o(lsu_rdy), .bru_wb_ready_o(bru_rdy),
    .alu_wb_tag_i(r_in[0].tag), .lsu_wb_tag_i(r_in[1].tag), .bru_wb_tag_i(r_in[2].tag),
    .alu_wb_data_i(r_in[0].data), .lsu_wb_data_i(r_in[1].data), .bru_wb_data_i(r_in[2].data),
    .alu_wb_rob_tag_i(r_in[0].rob), .lsu_wb_rob_tag_i(r_in[1].rob), .bru_wb_rob_tag_i(r_in[2].rob),
    .alu_wb_rd_used_i(r_in[0].rd), .lsu_wb_rd_used_i(r_in[1].rd), .bru_wb_rd_used_i(r_in[2].rd),
    .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o),
    .cdb_rob_tag_o(cdb_rob_tag_o), .cdb_rd_used_o(cdb_rd_used_o), .cdb_src_o(cdb_src_o)
  );

  // Reference model: one queue per source, a round-robin index and the expected bus contents.
  res_t mq [3][$];
  int   m_rr;
  logic m_valid;
  res_t m_bus;
  logic [1:0] m_src;
  bit   acc [3];
  int   cyc;
  int   n_checks = 0, n_errors = 0;

  function automatic res_t rand_res();
    res_t r;
    r.tag  = PREG_W'($urandom);
    r.data = $urandom;
    r.rob  = ROB_TAG_W'($urandom);
    r.rd   = 1'($urandom);
    return r;
  endfunction

  function automatic logic [2:0] m_rdy();
    return {mq[2].size() < DEPTH, mq[1].size() < DEPTH, mq[0].size() < DEPTH};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      mq[s].delete();
      acc[s] = 0;
    end
    m_rr = 0; m_valid = 1'b0; m_bus = '0; m_src = 2'd0;
  endtask

  // Advance one clock: update the model from the inputs seen at this edge, return at the falling edge.
  task automatic tick();
    bit rdy [3];
    int g;
    for (int s = 0; s < 3; s++) begin
      rdy[s] = mq[s].size() < DEPTH;
      acc[s] = 0;
    end
    if (rst) begin
      model_reset();
    end else if (flush) begin
      for (int s = 0; s < 3; s++) mq[s].delete();
      m_valid = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < 3; k++)
        if (g < 0 && mq[(m_rr + k) % 3].size() > 0) g = (m_rr + k) % 3;
      if (g >= 0) begin
        m_bus = mq[g].pop_front(); m_src = 2'(g); m_valid = 1'b1; m_rr = (g + 1) % 3;
      end else begin
        m_valid = 1'b0;
      end
      for (int s = 0; s < 3; s++)
        if (v_in[s] && rdy[s]) begin
          mq[s].push_back(r_in[s]);
          acc[s] = 1;
        end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // A source holds a refused result; otherwise it picks a fresh one.
  task automatic gen_inputs(input int pct);
    for (int s = 0; s < 3; s++)
      if (!(v_in[s] && !acc[s])) begin
        v_in[s] = ($urandom_range(99) < pct);
        r_in[s] = rand_res();
      end
  endtask

  task automatic test_reset();
    v_in = 3'b000; flush = 1'b0; rst = 1'b1;
    for (int s = 0; s < 3; s++) r_in[s] = '0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({cdb_valid_o, dut_bus, cdb_src_o} !== '0) begin
      n_errors++; $display("FAIL reset_bus got v=%b f=%h src=%0d want all zero", cdb_valid_o, dut_bus, cdb_src_o);
    end
    n_checks++;
    if (dut_rdy !== 3'b111) begin
      n_errors++; $display("FAIL reset_ready got %b want 111", dut_rdy);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_alu();
    res_t exp_r;
    exp_r = '{tag: 7'h12, data: 32'hDEADBEEF, rob: 5'd3, rd: 1'b1};
    r_in[0] = exp_r; v_in = 3'b001;
    tick();
    v_in = 3'b000;
    n_checks++;
    if (cdb_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL alu_early got valid=%b want 0", cdb_valid_o);
    end
    tick();
    n_checks++;
    if ({cdb_valid_o, dut_bus, cdb_src_o} !== {1'b1, exp_r, 2'd0}) begin
      n_errors++; $display("FAIL alu_bcast got v=%b f=%h src=%0d want v=1 f=%h src=0", cdb_valid_o, dut_bus, cdb_src_o, exp_r);
    end
    tick();
    n_checks++;
    if (cdb_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL alu_after got valid=%b want 0", cdb_valid_o);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] prev_src;
    logic prev_v = 1'b0;
    v_in = 3'b000;
    gen_inputs(100);
    for (int c = 0; c < 38; c++) begin
      tick();
      if (c < 29) gen_inputs(100); else v_in = 3'b000;
      n_checks++;
      if ({cdb_valid_o, dut_bus, cdb_src_o} !== {m_valid, m_bus, m_src}) begin
        n_errors++; $display("FAIL sat_bus cyc=%0d got v=%b f=%h src=%0d want v=%b f=%h src=%0d", cyc, cdb_valid_o, dut_bus, cdb_src_o, m_valid, m_bus, m_src);
      end
      n_checks++;
      if (dut_rdy !== m_rdy()) begin
        n_errors++; $display("FAIL sat_ready cyc=%0d got %b want %b", cyc, dut_rdy, m_rdy());
      end
      if (c < 30 && prev_v && cdb_valid_o) begin
        n_checks++;
        if (cdb_src_o !== ((prev_src == 2'd2) ? 2'd0 : prev_src + 2'd1)) begin
          n_errors++; $display("FAIL sat_rotation cyc=%0d got src=%0d after src=%0d", cyc, cdb_src_o, prev_src);
        end
      end
      prev_v = cdb_valid_o; prev_src = cdb_src_o;
    end
    n_checks++;
    if (cdb_valid_o !== 1'b0 || mq[0].size() + mq[1].size() + mq[2].size() != 0) begin
      n_errors++; $display("FAIL sat_drain got valid=%b want 0 with model empty", cdb_valid_o);
    end
  endtask

  task automatic test_lsu_b2b();
    res_t items [3];
    int idx = 0, nb = 0, last_cyc = -1;
    for (int i = 0; i < 3; i++) items[i] = rand_res();
    for (int c = 0; c < 10; c++) begin
      v_in = (idx < 3) ? 3'b010 : 3'b000;
      if (idx < 3) r_in[1] = items[idx];
      tick();
      if (acc[1]) idx++;
      n_checks++;
      if (dut_rdy !== m_rdy()) begin
        n_errors++; $display("FAIL lsu_ready cyc=%0d got %b want %b", cyc, dut_rdy, m_rdy());
      end
      if (cdb_valid_o) begin
        n_checks++;
        if (dut_bus !== items[nb > 2 ? 2 : nb] || cdb_src_o !== 2'd1 || (nb > 0 && cyc != last_cyc + 1)) begin
          n_errors++; $display("FAIL lsu_order n=%0d got f=%h src=%0d want f=%h src=1 back-to-back", nb, dut_bus, cdb_src_o, items[nb > 2 ? 2 : nb]);
        end
        last_cyc = cyc; nb++;
      end
    end
    v_in = 3'b000;
    n_checks++;
    if (nb != 3) begin
      n_errors++; $display("FAIL lsu_count got %0d broadcasts want 3", nb);
    end
  endtask

  task automatic test_bru_no_rd();
    res_t exp_r;
    exp_r = rand_res(); exp_r.rob = 5'd7; exp_r.rd = 1'b0;
    r_in[2] = exp_r; v_in = 3'b100;
    tick();
    v_in = 3'b000;
    tick();
    n_checks++;
    if ({cdb_valid_o, cdb_rd_used_o, cdb_rob_tag_o, cdb_src_o, dut_bus} !== {1'b1, 1'b0, 5'd7, 2'd2, exp_r}) begin
      n_errors++; $display("FAIL bru_nord got v=%b rd=%b rob=%0d src=%0d want v=1 rd=0 rob=7 src=2", cdb_valid_o, cdb_rd_used_o, cdb_rob_tag_o, cdb_src_o);
    end
    tick();
  endtask

  task automatic test_flush();
    gen_inputs(100);
    for (int c = 0; c < 8; c++) begin
      tick();
      gen_inputs(100);
    end
    n_checks++;
    if (dut_rdy !== m_rdy()) begin
      n_errors++; $display("FAIL flush_pre_ready got %b want %b", dut_rdy, m_rdy());
    end
    flush = 1'b1; v_in = 3'b111;
    for (int s = 0; s < 3; s++) r_in[s] = rand_res();
    tick();
    flush = 1'b0; v_in = 3'b000;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (cdb_valid_o !== 1'b0 || dut_rdy !== 3'b111) begin
        n_errors++; $display("FAIL flush_quiet c=%0d got valid=%b ready=%b want 0/111", c, cdb_valid_o, dut_rdy);
      end
      tick();
    end
    v_in = 3'b111;
    for (int s = 0; s < 3; s++) r_in[s] = rand_res();
    tick();
    v_in = 3'b000;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({cdb_valid_o, dut_bus, cdb_src_o} !== {m_valid, m_bus, m_src}) begin
        n_errors++; $display("FAIL flush_rr cyc=%0d got v=%b f=%h src=%0d want v=%b f=%h src=%0d", cyc, cdb_valid_o, dut_bus, cdb_src_o, m_valid, m_bus, m_src);
      end
    end
  endtask

  task automatic test_async_reset();
    gen_inputs(100);
    for (int c = 0; c < 5; c++) begin
      tick();
      gen_inputs(100);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (cdb_valid_o !== 1'b0 || dut_rdy !== 3'b111) begin
      n_errors++; $display("FAIL arst_immediate got valid=%b ready=%b want 0/111", cdb_valid_o, dut_rdy);
    end
    @(negedge clk);
    v_in = 3'b000;
    tick();
    rst = 1'b0;
    gen_inputs(100);
    tick();
    v_in = 3'b000;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({cdb_valid_o, cdb_src_o} !== {1'b1, 2'(c)} || dut_bus !== m_bus) begin
        n_errors++; $display("FAIL arst_order c=%0d got v=%b src=%0d f=%h want v=1 src=%0d f=%h", c, cdb_valid_o, cdb_src_o, dut_bus, c, m_bus);
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 310; c++) begin
      if (c < 300) begin
        gen_inputs(60);
        flush = ($urandom_range(99) < 3);
      end else begin
        v_in = 3'b000; flush = 1'b0;
      end
      tick();
      n_checks++;
      if ({cdb_valid_o, dut_bus, cdb_src_o} !== {m_valid, m_bus, m_src}) begin
        n_errors++; $display("FAIL rand_bus cyc=%0d got v=%b f=%h src=%0d want v=%b f=%h src=%0d", cyc, cdb_valid_o, dut_bus, cdb_src_o, m_valid, m_bus, m_src);
      end
      n_checks++;
      if (dut_rdy !== m_rdy()) begin
        n_errors++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, dut_rdy, m_rdy());
      end
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_single_alu();
    test_saturation();
    test_lsu_b2b();
    test_bru_no_rd();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
